// File: rtl/multicycle_processor.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB state machine with
// an internal register file and req/ready handshakes to external memories.
module multicycle_processor #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ready,
    output logic            retire,
    output logic [XLEN-1:0] pc_out,
    output logic            halted,
    output logic            error
);

    localparam int         RIW     = $clog2(NREGS);
    // Register-index bits that must be zero for this register-file size.
    localparam logic [4:0] HI_MASK = ~5'(NREGS - 1);

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_SYS = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            err_q, err_d;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] a_q, b_q, imm_q, res_q, mdr_q;
    logic            dmem_we_q;
    logic [XLEN-1:0] dmem_addr_q, dmem_wdata_q;
    logic [XLEN-1:0] rf_q [NREGS];
    logic            rf_we;

    // Instruction fields
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rd_f, rs1_f, rs2_f;
    assign opc   = ir_q[6:0];
    assign rd_f  = ir_q[11:7];
    assign f3    = ir_q[14:12];
    assign rs1_f = ir_q[19:15];
    assign rs2_f = ir_q[24:20];
    assign f7    = ir_q[31:25];

    logic [RIW-1:0] rd_idx, rs1_idx, rs2_idx;
    assign rd_idx  = rd_f[RIW-1:0];
    assign rs1_idx = rs1_f[RIW-1:0];
    assign rs2_idx = rs2_f[RIW-1:0];

    logic is_r, is_addi, is_lw, is_sw, is_br, is_jal, is_ecall, legal;

    // Classify the latched instruction; anything unrecognised is illegal.
    always_comb begin
        is_r     = 1'b0;
        is_addi  = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_br    = 1'b0;
        is_jal   = 1'b0;
        is_ecall = 1'b0;
        case (opc)
            OPC_R:   is_r = (f7 == 7'h00 && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110)) ||
                            (f7 == 7'h20 && f3 == 3'b000);
            OPC_I:   is_addi = (f3 == 3'b000);
            OPC_LD:  is_lw = (f3 == 3'b010);
            OPC_ST:  is_sw = (f3 == 3'b010);
            OPC_BR:  is_br = (f3 == 3'b000 || f3 == 3'b001);
            OPC_JAL: is_jal = 1'b1;
            OPC_SYS: is_ecall = (ir_q == 32'h0000_0073);
            default: ;
        endcase
        // Only fields the format actually uses are range-checked.
        legal = (is_r || is_addi || is_lw || is_sw || is_br || is_jal || is_ecall) &&
                !((is_r || is_addi || is_lw || is_jal) && (rd_f & HI_MASK) != 5'd0) &&
                !((is_r || is_addi || is_lw || is_sw || is_br) && (rs1_f & HI_MASK) != 5'd0) &&
                !((is_r || is_sw || is_br) && (rs2_f & HI_MASK) != 5'd0);
    end

    logic [XLEN-1:0] imm_gen;

    // Sign-extended immediate for the instruction's format.
    always_comb begin
        imm_gen = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
        if (is_sw)
            imm_gen = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        else if (is_br)
            imm_gen = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
        else if (is_jal)
            imm_gen = {{(XLEN-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    end

    logic [XLEN-1:0] rs1_v, rs2_v;
    assign rs1_v = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
    assign rs2_v = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];

    logic [XLEN-1:0] pc_plus4, addr, alu_res;
    logic            taken;
    assign pc_plus4 = pc_q + XLEN'(4);
    assign addr     = a_q + imm_q;
    assign taken    = (a_q == b_q) ^ f3[0];

    // EXEC result: ALU op, or link address for jal.
    always_comb begin
        alu_res = a_q + imm_q;
        if (is_jal)
            alu_res = pc_plus4;
        else if (is_r) begin
            case (f3)
                3'b111:  alu_res = a_q & b_q;
                3'b110:  alu_res = a_q | b_q;
                default: alu_res = f7[5] ? (a_q - b_q) : (a_q + b_q);
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next state, PC update, retire and register-file write enable.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        retire  = 1'b0;
        rf_we   = 1'b0;
        case (state_q)
            S_FETCH: if (imem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (!legal) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else if (is_ecall) begin
                    state_d = S_HALT;
                    err_d   = 1'b0;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    if (addr[1:0] != 2'b00) begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_MEM;
                    end
                end else if (is_br) begin
                    pc_d    = taken ? (pc_q + imm_q) : pc_plus4;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        pc_d    = pc_plus4;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_d    = is_jal ? (pc_q + imm_q) : pc_plus4;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: ;  // S_HALT absorbs until reset
        endcase
    end

    // Datapath registers: PC, IR, operand latches, data-port registers, MDR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            err_q        <= 1'b0;
            ir_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            imm_q        <= '0;
            res_q        <= '0;
            mdr_q        <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
            if (state_q == S_FETCH && imem_ready) ir_q <= imem_rdata;
            if (state_q == S_DECODE) begin
                a_q   <= rs1_v;
                b_q   <= rs2_v;
                imm_q <= imm_gen;
            end
            // Data-port registers only move in EXEC, so they are frozen across MEM.
            if (state_q == S_EXEC) begin
                res_q        <= alu_res;
                dmem_we_q    <= is_sw;
                dmem_addr_q  <= addr;
                dmem_wdata_q <= b_q;
            end
            if (state_q == S_MEM && dmem_ready) mdr_q <= dmem_rdata;
        end
    end

    // Register file; x0 is never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (rf_we && rd_idx != '0) begin
            rf_q[rd_idx] <= is_lw ? mdr_q : res_q;
        end
    end

    // Requests are masked while reset is held so the ports read idle.
    assign imem_req   = rst_n && (state_q == S_FETCH);
    assign dmem_req   = rst_n && (state_q == S_MEM);
    assign imem_addr  = pc_q;
    assign pc_out     = pc_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign halted     = (state_q == S_HALT);
    assign error      = err_q;

endmodule

// File: tb/tb_multicycle_processor.sv
// Bench for multicycle_processor: an instruction-level model predicts the
// per-cycle port behaviour; memories are modelled with fixed wait counts.
module tb_multicycle_processor;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic        retire, halted, error;
    logic [31:0] pc_out;

    multicycle_processor dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .retire(retire), .pc_out(pc_out), .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    int          wi = 0, wd = 0, cyc = 0, halt_cyc = 1000;
    bit          spur = 0, force_rdy = 0, cmp_en = 0, exp_err = 0;
    logic [31:0] im [64], dm [64], md [64], mreg [32], mfinal_pc;
    bit          exp_ret [512], exp_ireq [512], exp_dreq [512], exp_dwe [512];
    logic [31:0] exp_pc [512], exp_daddr [512], exp_dwd [512];

    localparam logic [31:0] ECALL = 32'h0000_0073;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] e_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] e_s(input logic [11:0] imm, input logic [4:0] rs2, rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] e_b(input logic [12:0] imm, input logic [4:0] rs2, rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] e_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    // ISA-level interpreter producing the expected per-cycle port timeline.
    task automatic model_run();
        int c, k;
        logic [31:0] pc, ins, r1, r2, res, a, iimm, simm, bimm, jimm;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [4:0] rd;
        for (int i = 0; i < 512; i++) begin
            exp_ret[i] = 0; exp_ireq[i] = 0; exp_dreq[i] = 0; exp_dwe[i] = 0;
            exp_pc[i] = 0; exp_daddr[i] = 0; exp_dwd[i] = 0;
        end
        for (int i = 0; i < 32; i++) mreg[i] = 0;
        for (int i = 0; i < 64; i++) md[i] = dm[i];
        c = 0; pc = 0; halt_cyc = 1000; exp_err = 0;
        for (int n = 0; n < 64 && halt_cyc == 1000 && c < 480; n++) begin
            ins = im[pc[7:2]];
            op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; rd = ins[11:7];
            r1 = mreg[ins[19:15]]; r2 = mreg[ins[24:20]];
            iimm = {{20{ins[31]}}, ins[31:20]};
            simm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            bimm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            jimm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            k = 0; res = 0;
            if (ins == ECALL) k = 1;
            else if (op == 7'h33 && f3 == 0 && f7 == 0) begin k = 2; res = r1 + r2; end
            else if (op == 7'h33 && f3 == 0 && f7 == 7'h20) begin k = 2; res = r1 - r2; end
            else if (op == 7'h33 && f3 == 7 && f7 == 0) begin k = 2; res = r1 & r2; end
            else if (op == 7'h33 && f3 == 6 && f7 == 0) begin k = 2; res = r1 | r2; end
            else if (op == 7'h13 && f3 == 0) begin k = 2; res = r1 + iimm; end
            else if (op == 7'h03 && f3 == 2) k = 4;
            else if (op == 7'h23 && f3 == 2) k = 5;
            else if (op == 7'h63 && (f3 == 0 || f3 == 1)) k = 6;
            else if (op == 7'h6f) k = 7;
            for (int w = 0; w <= wi; w++) begin c++; exp_ireq[c] = 1; exp_pc[c] = pc; end
            c++; exp_pc[c] = pc;                       // decode
            if (k <= 1) begin
                halt_cyc = c + 1; exp_err = (k == 0);
            end else begin
                c++; exp_pc[c] = pc;                   // execute
                if (k == 2) begin
                    c++; exp_pc[c] = pc; exp_ret[c] = 1;
                    if (rd != 0) mreg[rd] = res;
                    pc = pc + 4;
                end else if (k == 4 || k == 5) begin
                    a = r1 + ((k == 4) ? iimm : simm);
                    if (a[1:0] != 0) begin
                        halt_cyc = c + 1; exp_err = 1;
                    end else begin
                        for (int w = 0; w <= wd; w++) begin
                            c++; exp_pc[c] = pc; exp_dreq[c] = 1;
                            exp_daddr[c] = a; exp_dwe[c] = (k == 5); exp_dwd[c] = r2;
                        end
                        if (k == 4) begin
                            c++; exp_pc[c] = pc; exp_ret[c] = 1;
                            if (rd != 0) mreg[rd] = md[a[7:2]];
                        end else begin
                            exp_ret[c] = 1; md[a[7:2]] = r2;
                        end
                        pc = pc + 4;
                    end
                end else if (k == 6) begin
                    exp_ret[c] = 1;
                    pc = (((r1 == r2) ? 1 : 0) ^ f3[0]) ? pc + bimm : pc + 4;
                end else begin
                    c++; exp_pc[c] = pc; exp_ret[c] = 1;
                    if (rd != 0) mreg[rd] = pc + 4;
                    pc = pc + jimm;
                end
            end
        end
        mfinal_pc = pc;
        for (int i = halt_cyc; i < 512; i++) exp_pc[i] = pc;
    endtask

    // Memory responders: ready after a fixed number of wait cycles.
    initial begin
        int icnt, dcnt;
        icnt = 0; dcnt = 0;
        imem_ready = 0; imem_rdata = 0; dmem_ready = 0; dmem_rdata = 0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (icnt == wi) begin imem_ready = 1; imem_rdata = im[imem_addr[7:2]]; icnt = 0; end
                else begin imem_ready = 0; imem_rdata = 32'hFFFF_FFFF; icnt++; end
            end else begin
                imem_ready = spur | force_rdy; imem_rdata = 32'hFFFF_FFFF; icnt = 0;
            end
            if (dmem_req) begin
                if (dcnt == wd) begin
                    dmem_ready = 1; dmem_rdata = dm[dmem_addr[7:2]]; dcnt = 0;
                    if (dmem_we) dm[dmem_addr[7:2]] = dmem_wdata;
                end else begin dmem_ready = 0; dmem_rdata = 32'hFFFF_FFFF; dcnt++; end
            end else begin
                dmem_ready = spur; dmem_rdata = 32'hFFFF_FFFF; dcnt = 0;
            end
        end
    end

    // Per-cycle comparison of the DUT ports against the model timeline.
    initial begin
        forever begin
            @(negedge clk); #2;
            if (!rst_n) cyc = 0;
            else begin
                cyc++;
                if (cmp_en && cyc < 512) begin
                    chk("retire", retire, exp_ret[cyc]);
                    chk("halted", halted, cyc >= halt_cyc);
                    chk("error", error, (cyc >= halt_cyc) ? exp_err : 1'b0);
                    chk("pc_out", pc_out, exp_pc[cyc]);
                    chk("imem_addr", imem_addr, exp_pc[cyc]);
                    chk("imem_req", imem_req, exp_ireq[cyc]);
                    chk("dmem_req", dmem_req, exp_dreq[cyc]);
                    if (exp_dreq[cyc]) begin
                        chk("dmem_addr", dmem_addr, exp_daddr[cyc]);
                        chk("dmem_we", dmem_we, exp_dwe[cyc]);
                        if (exp_dwe[cyc]) chk("dmem_wdata", dmem_wdata, exp_dwd[cyc]);
                    end
                end
            end
        end
    end

    task automatic load_clear();
        for (int i = 0; i < 64; i++) begin im[i] = 32'h0; dm[i] = 32'h0; end
    endtask

    task automatic run_prog(input int iw, input int dw, input bit sp, input bit do_reset);
        wi = iw; wd = dw; spur = sp;
        model_run();
        if (do_reset) begin
            @(posedge clk); #1 rst_n = 0;
            @(posedge clk);
            @(negedge clk); #3;
            chk("rst_imem_req", imem_req, 0);
            chk("rst_dmem_req", dmem_req, 0);
            chk("rst_retire", retire, 0);
            chk("rst_halted", halted, 0);
            chk("rst_error", error, 0);
            chk("rst_pc", pc_out, 0);
            chk("rst_dmem_addr", dmem_addr, 0);
        end
        cmp_en = 1;
        @(posedge clk); #1 rst_n = 1; force_rdy = 0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk); #3;
            if (cyc >= halt_cyc + 3) break;
        end
        chk("run_done", cyc >= halt_cyc + 3, 1);
        cmp_en = 0; spur = 0;
        for (int i = 0; i < 16; i++) chk("dmem_image", dm[i], md[i]);
    endtask

    initial begin
        int nret;
        // T1: reset and sequencing
        load_clear();
        im[0] = e_i(12'd5, 0, 0, 1, 7'h13);
        im[1] = e_i(12'hFFD, 0, 0, 2, 7'h13);
        im[2] = e_r(7'h00, 2, 1, 0, 3);
        im[3] = ECALL;
        run_prog(0, 0, 0, 1);
        nret = 0;
        for (int i = 0; i < 512; i++) nret += exp_ret[i];
        chk("t1_model_pc", mfinal_pc, 32'd12);
        chk("t1_model_x3", mreg[3], 32'd2);
        chk("t1_ret_cycles", {exp_ret[4], exp_ret[8], exp_ret[12]}, 3'b111);
        chk("t1_nret", nret, 3);
        chk("t1_halt_cyc", halt_cyc, 15);
        chk("t1_err", exp_err, 0);

        // T2: load/store with three data wait states
        load_clear();
        dm[4] = 32'hDEAD_BEEF;
        im[0] = e_i(12'd16, 0, 3'b010, 1, 7'h03);
        im[1] = e_s(12'd8, 1, 0);
        im[2] = e_i(12'd8, 0, 3'b010, 4, 7'h03);
        im[3] = e_s(12'd12, 4, 0);
        im[4] = ECALL;
        run_prog(0, 3, 0, 1);
        chk("t2_sw_mem", dm[2], 32'hDEAD_BEEF);
        chk("t2_lw_x4", dm[3], 32'hDEAD_BEEF);
        chk("t2_model_lw_8cyc", {exp_ret[15], exp_ret[22], exp_ret[23]}, 3'b101);
        chk("t2_model_st_addr", exp_daddr[12], 32'd8);

        // T3a: bne taken backwards from 0x20
        load_clear();
        im[0] = e_i(12'd1, 0, 0, 1, 7'h13);
        im[1] = e_i(12'd2, 0, 0, 2, 7'h13);
        im[2] = e_j(21'd24, 0);
        im[6] = ECALL;
        im[8] = e_b(13'h1FF8, 2, 1, 3'b001);
        run_prog(0, 0, 0, 1);
        chk("t3a_model_pc", mfinal_pc, 32'h18);
        chk("t3a_model_br3", exp_ret[15], 1);

        // T3b: beq not taken, one fetch wait state
        im[8] = e_b(13'h1FF8, 2, 1, 3'b000);
        im[9] = ECALL;
        run_prog(1, 0, 0, 1);
        chk("t3b_model_pc", mfinal_pc, 32'h24);
        chk("t3b_model_br", exp_ret[19], 1);

        // T4: jal link and x0 write discard
        load_clear();
        dm[1] = 32'hCAFE_F00D;
        im[0]  = e_j(21'd64, 0);
        im[16] = e_j(21'd16, 5);
        im[20] = e_i(12'd7, 0, 0, 0, 7'h13);
        im[21] = e_s(12'd0, 5, 0);
        im[22] = e_s(12'd4, 0, 0);
        im[23] = ECALL;
        run_prog(0, 0, 0, 1);
        chk("t4_x5", dm[0], 32'h44);
        chk("t4_x0", dm[1], 32'h0);
        chk("t4_model_pc", mfinal_pc, 32'h5C);

        // T5: misaligned load faults before any data request
        load_clear();
        im[0] = e_i(12'd2, 0, 0, 1, 7'h13);
        im[1] = e_i(12'd4, 1, 3'b010, 2, 7'h03);
        run_prog(0, 0, 0, 1);
        chk("t5_model_pc", mfinal_pc, 32'd4);
        chk("t5_model_err", exp_err, 1);
        chk("t5_model_halt", halt_cyc, 8);

        // T6: illegal opcode 0x7F
        load_clear();
        im[0] = 32'h0000_007F;
        run_prog(0, 0, 0, 1);
        chk("t6_model_pc", mfinal_pc, 32'd0);
        chk("t6_model_halt", halt_cyc, 3);

        // T7: reset while a fetch is waiting; registers must come back cleared
        load_clear();
        im[0] = e_s(12'd0, 1, 0);
        im[1] = e_i(12'd9, 0, 0, 1, 7'h13);
        im[2] = ECALL;
        wi = 5; wd = 0; cmp_en = 0;
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        repeat (21) @(negedge clk);
        #3;
        chk("t7_fetch_pending", imem_req, 1);
        chk("t7_fetch_addr", imem_addr, 32'd8);
        @(posedge clk); #1 rst_n = 0; force_rdy = 1;
        dm[0] = 32'h1234_5678;
        run_prog(5, 0, 0, 0);
        chk("t7_x1_cleared", dm[0], 32'h0);

        // T8: ALU ops, with stray ready pulses while no request is open
        load_clear();
        im[0] = e_i(12'd5, 0, 0, 1, 7'h13);
        im[1] = e_i(12'hFFD, 0, 0, 2, 7'h13);
        im[2] = e_r(7'h00, 2, 1, 0, 3);
        im[3] = e_r(7'h20, 2, 1, 0, 4);
        im[4] = e_r(7'h00, 2, 1, 7, 5);
        im[5] = e_r(7'h00, 2, 1, 6, 6);
        im[6] = e_s(12'd0, 3, 0);
        im[7] = e_s(12'd4, 4, 0);
        im[8] = e_s(12'd8, 5, 0);
        im[9] = e_s(12'd12, 6, 0);
        im[10] = ECALL;
        run_prog(0, 0, 1, 1);
        chk("t8_add", dm[0], 32'd2);
        chk("t8_sub", dm[1], 32'd8);
        chk("t8_and", dm[2], 32'd5);
        chk("t8_or", dm[3], 32'hFFFF_FFFD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
